// File: rtl/tlc_phase_sequencer.sv
// Phase scheduler for a two-road junction with a pedestrian crossing.
// Registered Moore FSM with a tick-driven phase timer and latched service requests.
module tlc_phase_sequencer #(
    parameter int CW        = 6,
    parameter int GREEN_MAJ = 30,
    parameter int GREEN_MIN = 10,
    parameter int YELLOW    = 5,
    parameter int ALLRED    = 2,
    parameter int PED_TIME  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       night_sensor,
    input  logic       minor_req,
    input  logic       ped_req,
    input  logic       emerg_req,
    output logic [2:0] maj_lamp,
    output logic [2:0] min_lamp,
    output logic       ped_walk,
    output logic       ped_ack,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {
        FLASH = 3'd0, MAJ_G = 3'd1, MAJ_Y = 3'd2, AR_A = 3'd3,
        MIN_G = 3'd4, MIN_Y = 3'd5, AR_B  = 3'd6, PED  = 3'd7
    } state_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_timer;
    logic          r_minor_pend;
    logic          r_ped_pend;
    logic          r_ped_ack;
    logic          w_timed;
    logic          w_enter;

    // Timer holds remaining ticks minus one; FLASH is untimed.
    function automatic logic [CW-1:0] dur_m1(input state_t s);
        case (s)
            MAJ_G:        return CW'(GREEN_MAJ - 1);
            MIN_G:        return CW'(GREEN_MIN - 1);
            MAJ_Y, MIN_Y: return CW'(YELLOW - 1);
            AR_A, AR_B:   return CW'(ALLRED - 1);
            PED:          return CW'(PED_TIME - 1);
            default:      return '0;
        endcase
    endfunction

    always_comb begin
        w_timed = tick && (r_timer == '0);
        w_next  = r_state;
        case (r_state)
            FLASH: if (!night_sensor || emerg_req) w_next = AR_B;
            MAJ_G: if (w_timed && !emerg_req && (r_minor_pend || r_ped_pend || night_sensor))
                       w_next = MAJ_Y;
            MAJ_Y: if (w_timed) w_next = AR_A;
            AR_A: begin
                if (w_timed) begin
                    if (emerg_req)         w_next = MAJ_G;
                    else if (night_sensor) w_next = FLASH;
                    else if (r_ped_pend)   w_next = PED;
                    else if (r_minor_pend) w_next = MIN_G;
                    else                   w_next = MAJ_G;
                end
            end
            MIN_G: if (w_timed || emerg_req) w_next = MIN_Y;
            MIN_Y: if (w_timed) w_next = AR_B;
            AR_B:  if (w_timed) w_next = (night_sensor && !emerg_req) ? FLASH : MAJ_G;
            PED:   if (w_timed || emerg_req) w_next = AR_B;
            default: w_next = AR_B;
        endcase
        w_enter = (w_next != r_state);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= AR_B;
            r_timer      <= CW'(ALLRED - 1);
            r_minor_pend <= 1'b0;
            r_ped_pend   <= 1'b0;
            r_ped_ack    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_enter)
                r_timer <= dur_m1(w_next);
            else if (tick && (r_timer != '0))
                r_timer <= r_timer - CW'(1);
            // A request arriving on the serving edge is absorbed by that service.
            r_minor_pend <= (w_enter && w_next == MIN_G) ? 1'b0 : (r_minor_pend | minor_req);
            r_ped_pend   <= (w_enter && w_next == PED)   ? 1'b0 : (r_ped_pend | ped_req);
            r_ped_ack    <= w_enter && (w_next == PED);
        end
    end

    always_comb begin
        maj_lamp = LAMP_R;
        min_lamp = LAMP_R;
        case (r_state)
            FLASH: begin maj_lamp = LAMP_Y; min_lamp = LAMP_Y; end
            MAJ_G: maj_lamp = LAMP_G;
            MAJ_Y: maj_lamp = LAMP_Y;
            MIN_G: min_lamp = LAMP_G;
            MIN_Y: min_lamp = LAMP_Y;
            default: ;
        endcase
    end

    assign ped_walk = (r_state == PED);
    assign ped_ack  = r_ped_ack;
    assign phase    = r_state;
endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Scoreboarded bench for tlc_phase_sequencer: directed junction scenarios followed by
// randomized traffic, checked against a tick-counting behavioural model of the phase rules.
module tb_tlc_phase_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       night_sensor = 1'b0;
    logic       minor_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       emerg_req = 1'b0;
    logic [2:0] maj_lamp, min_lamp, phase;
    logic       ped_walk, ped_ack;

    tlc_phase_sequencer dut (
        .clk(clk), .rst(rst), .tick(tick), .night_sensor(night_sensor),
        .minor_req(minor_req), .ped_req(ped_req), .emerg_req(emerg_req),
        .maj_lamp(maj_lamp), .min_lamp(min_lamp), .ped_walk(ped_walk),
        .ped_ack(ped_ack), .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         rst;
        logic [2:0] ph;
        logic [2:0] maj;
        logic [2:0] mn;
        logic       walk;
        logic       ack;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cur    = 0;

    // Reference model: phase number, ticks already spent in it, request memory.
    int m_ph = 6;
    int m_el = 0;
    bit m_mp = 0, m_pp = 0, m_ack = 0;

    function automatic int dur(input int p);
        case (p)
            1: return 30;
            4: return 10;
            2, 5: return 5;
            3, 6: return 2;
            7: return 8;
            default: return 1;
        endcase
    endfunction

    function automatic logic [2:0] maj_of(input int p);
        if (p == 1) return 3'b001;
        if (p == 2 || p == 0) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] min_of(input int p);
        if (p == 4) return 3'b001;
        if (p == 5 || p == 0) return 3'b010;
        return 3'b100;
    endfunction

    task automatic step();
        exp_t e;
        int   nx;
        bit   timed;
        if (rst) begin
            m_ph = 6; m_el = 0; m_mp = 0; m_pp = 0; m_ack = 0;
        end else begin
            timed = tick && (m_el == dur(m_ph) - 1);
            nx = m_ph;
            case (m_ph)
                0: if (!night_sensor || emerg_req) nx = 6;
                1: if (timed && !emerg_req && (m_mp || m_pp || night_sensor)) nx = 2;
                2: if (timed) nx = 3;
                3: if (timed) nx = emerg_req ? 1 : night_sensor ? 0 : m_pp ? 7 : m_mp ? 4 : 1;
                4: if (timed || emerg_req) nx = 5;
                5: if (timed) nx = 6;
                6: if (timed) nx = (night_sensor && !emerg_req) ? 0 : 1;
                default: if (timed || emerg_req) nx = 6;
            endcase
            m_mp  = (nx == 4 && m_ph != 4) ? 1'b0 : (m_mp | minor_req);
            m_pp  = (nx == 7 && m_ph != 7) ? 1'b0 : (m_pp | ped_req);
            m_ack = (nx == 7 && m_ph != 7);
            if (nx != m_ph) m_el = 0;
            else if (tick && m_el < dur(m_ph) - 1) m_el++;
            m_ph = nx;
        end
        e.cyc  = cur + 1;
        e.rst  = rst;
        e.ph   = 3'(m_ph);
        e.maj  = maj_of(m_ph);
        e.mn   = min_of(m_ph);
        e.walk = (m_ph == 7);
        e.ack  = m_ack;
        q.push_back(e);
        @(posedge clk);
        cur++;
        #1;
    endtask

    task automatic wait_ph(input int ph);
        for (int i = 0; i < 300; i++) begin
            if (m_ph == ph) return;
            step();
        end
        checks++;
        errors++;
        $display("FAIL wait_phase: model never reached phase %0d, now %0d", ph, m_ph);
    endtask

    task automatic pulse_minor();
        minor_req = 1'b1; step(); minor_req = 1'b0;
    endtask

    task automatic pulse_ped();
        ped_req = 1'b1; step(); ped_req = 1'b0;
    endtask

    // Monitor: compares every presented cycle and checks the junction safety rules.
    initial begin
        int         cnt = 0;
        logic [2:0] pmaj = 3'b100;
        logic [2:0] pmin = 3'b100;
        exp_t       e;
        forever begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cnt) begin
                e = q.pop_front();
                checks++;
                if (phase !== e.ph || maj_lamp !== e.maj || min_lamp !== e.mn ||
                    ped_walk !== e.walk || ped_ack !== e.ack) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d: got ph=%0d maj=%b min=%b walk=%b ack=%b, want ph=%0d maj=%b min=%b walk=%b ack=%b",
                             e.cyc, phase, maj_lamp, min_lamp, ped_walk, ped_ack,
                             e.ph, e.maj, e.mn, e.walk, e.ack);
                end
                checks++;
                if (phase != 3'd0 && maj_lamp != 3'b100 && min_lamp != 3'b100) begin
                    errors++;
                    $display("FAIL both_go cyc=%0d: maj=%b min=%b, need one red", e.cyc, maj_lamp, min_lamp);
                end
                checks++;
                if (ped_walk && (maj_lamp != 3'b100 || min_lamp != 3'b100)) begin
                    errors++;
                    $display("FAIL walk_conflict cyc=%0d: maj=%b min=%b, need both red", e.cyc, maj_lamp, min_lamp);
                end
                checks++;
                if (!e.rst && ((pmaj == 3'b001 && maj_lamp == 3'b100) ||
                               (pmin == 3'b001 && min_lamp == 3'b100))) begin
                    errors++;
                    $display("FAIL green_to_red cyc=%0d: maj %b->%b min %b->%b, need yellow between",
                             e.cyc, pmaj, maj_lamp, pmin, min_lamp);
                end
                pmaj = maj_lamp;
                pmin = min_lamp;
            end
        end
    end

    initial begin
        // 1: reset, tick every clk, idle -> AR_B then MAJ_G held
        rst = 1'b1; tick = 1'b1; step();
        rst = 1'b0; repeat (45) step();

        // 2: minor pulse a few clk into MAJ_G -> full minor cycle
        rst = 1'b1; step(); rst = 1'b0;
        repeat (7) step();
        pulse_minor();
        repeat (60) step();

        // 3: ped and minor together -> ped served first, minor after next green
        ped_req = 1'b1; minor_req = 1'b1; step();
        ped_req = 1'b0; minor_req = 1'b0;
        repeat (130) step();

        // 4: emergency during MIN_G, then held MAJ_G with minor pending
        pulse_minor();
        wait_ph(4);
        repeat (2) step();
        emerg_req = 1'b1;
        repeat (20) step();
        pulse_minor();
        repeat (40) step();
        emerg_req = 1'b0;
        repeat (60) step();

        // 5: night flash, exit on sensor drop and on emergency
        night_sensor = 1'b1;
        wait_ph(0);
        repeat (5) step();
        night_sensor = 1'b0;
        repeat (40) step();
        night_sensor = 1'b1;
        wait_ph(0);
        emerg_req = 1'b1; repeat (3) step();
        emerg_req = 1'b0; night_sensor = 1'b0;
        repeat (10) step();

        // 6: reset mid-MIN_G with ped pending
        pulse_minor();
        wait_ph(4);
        pulse_ped();
        repeat (3) step();
        rst = 1'b1; step(); rst = 1'b0;
        repeat (80) step();

        // Randomized traffic with sparse ticks
        for (int i = 0; i < 6000; i++) begin
            tick      = ($urandom_range(0, 2) == 0);
            minor_req = ($urandom_range(0, 19) == 0);
            ped_req   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 199) == 0) emerg_req = ~emerg_req;
            if ($urandom_range(0, 399) == 0) night_sensor = ~night_sensor;
            rst       = ($urandom_range(0, 999) == 0);
            step();
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, need 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
